// File: rtl/instr_encoder.sv
// Instruction field encoder: checks legality, packs 16-bit code words and
// buffers them in a small FIFO with a RUN/HALTED gate on the input side.
module instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [3:0]    in_fc,
    input  logic [3:0]    in_ra,
    input  logic [3:0]    in_rb,
    input  logic [11:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_code,
    output logic [CW-1:0] count,
    output logic          halted,
    input  logic          resume,
    output logic          err,
    output logic [1:0]    err_code
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic [15:0]   enc_word;
    logic [1:0]    enc_err;
    logic          accept, push, pop, full;

    // Encoder; enc_err == 2'b00 means the bundle is legal.
    always_comb begin
        enc_word = 16'h0000;
        enc_err  = 2'b00;
        case (in_op)
            4'hF: begin
                enc_word = {in_op, in_ra, in_rb, in_fc};
                case (in_fc)
                    4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8: enc_err = 2'b00;
                    default:                            enc_err = 2'b10;
                endcase
            end
            4'h8, 4'h9: begin
                enc_word = {in_op, in_ra, in_imm[7:0]};
                if (in_imm[11:8] != 4'h0) enc_err = 2'b11;
            end
            4'hA, 4'hB, 4'hC, 4'hD: begin
                enc_word = {in_op, in_ra, in_imm[3:0], in_rb};
                if (in_imm[11:4] != 8'h00) enc_err = 2'b11;
            end
            4'h4, 4'h5, 4'h6: begin
                enc_word = {in_op, in_ra, in_imm[7:0]};
                if (in_imm[11:8] != {4{in_imm[7]}}) enc_err = 2'b11;
            end
            4'h1:    enc_word = {in_op, in_imm};
            4'h0:    enc_word = 16'h0000;
            default: enc_err  = 2'b01;
        endcase
    end

    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full && (state_q == StRun);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (enc_err == 2'b00);
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        if (accept && (enc_err != 2'b00)) begin
            err_d      = 1'b1;
            err_code_d = enc_err;
        end

        case (state_q)
            StRun:    if (push && (in_op == 4'h0)) state_d = StHalted;
            StHalted: if (resume) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StRun;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign out_code = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign halted   = (state_q == StHalted);
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
